// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with dual in-order allocation, two writeback
// capture buses and in-order retirement of up to two entries per cycle.
// The entry index handed out at allocation is the ROB tag the register file
// stores alongside each busy bit.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync squash of all entries)
//   alloc0_*/alloc1_*   : allocation requests, slot 0 is the older one
//   alloc_ready         : at least two entries free
//   alloc0/1_tag        : tags the next accepted allocations receive
//   res0_*/res1_*       : writeback buses (tag + 16-bit data)
//   wen/waddr/wdata 0/1 : registered register-file write ports (port 1 is younger)
//   commit_count        : entries retired at the last edge
//   occupancy           : number of valid entries
module rob_commit #(
  parameter int DEPTH = 64,
  parameter int TAGW  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc0_valid,
  input  logic            alloc0_wen,
  input  logic [2:0]      alloc0_rd,
  input  logic            alloc1_valid,
  input  logic            alloc1_wen,
  input  logic [2:0]      alloc1_rd,
  output logic            alloc_ready,
  output logic [TAGW-1:0] alloc0_tag,
  output logic [TAGW-1:0] alloc1_tag,
  input  logic            res0_valid,
  input  logic [TAGW-1:0] res0_tag,
  input  logic [15:0]     res0_data,
  input  logic            res1_valid,
  input  logic [TAGW-1:0] res1_tag,
  input  logic [15:0]     res1_data,
  output logic            wen0,
  output logic [2:0]      waddr0,
  output logic [15:0]     wdata0,
  output logic            wen1,
  output logic [2:0]      waddr1,
  output logic [15:0]     wdata1,
  output logic [1:0]      commit_count,
  output logic [TAGW:0]   occupancy
);

  localparam logic [TAGW:0] READY_LIMIT = (TAGW+1)'(DEPTH - 2);

  logic [TAGW-1:0] r_head;
  logic [TAGW-1:0] r_tail;
  logic [TAGW:0]   r_count;

  logic            r_valid [DEPTH];
  logic            r_done  [DEPTH];
  logic            r_wen   [DEPTH];
  logic [2:0]      r_rd    [DEPTH];
  logic [15:0]     r_data  [DEPTH];

  logic [TAGW-1:0] w_head1;
  logic [TAGW-1:0] w_tail1;
  logic            w_acc0;
  logic            w_acc1;
  logic            w_fire0;
  logic            w_fire1;
  logic [1:0]      w_n_acc;
  logic [1:0]      w_n_ret;

  assign w_head1     = r_head + TAGW'(1);
  assign w_tail1     = r_tail + TAGW'(1);
  assign alloc_ready = (r_count <= READY_LIMIT);
  assign alloc0_tag  = r_tail;
  assign alloc1_tag  = w_tail1;
  assign occupancy   = r_count;

  // The younger allocation is only honoured alongside the older one.
  assign w_acc0  = alloc_ready && alloc0_valid;
  assign w_acc1  = w_acc0 && alloc1_valid;

  // Retirement looks only at pre-edge state, so a result captured at this
  // edge becomes retirable at the following one.
  assign w_fire0 = r_valid[r_head] && r_done[r_head];
  assign w_fire1 = w_fire0 && r_valid[w_head1] && r_done[w_head1];

  // Slot 1 implies slot 0, so the pair encodes directly as a 0..2 count.
  assign w_n_acc = {w_acc1, w_acc0 & ~w_acc1};
  assign w_n_ret = {w_fire1, w_fire0 & ~w_fire1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      wen0         <= 1'b0;
      wen1         <= 1'b0;
      waddr0       <= '0;
      waddr1       <= '0;
      wdata0       <= '0;
      wdata1       <= '0;
      commit_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
      end
    end else if (flush) begin
      // Squash everything; the register-file address/data lines keep their
      // last values since wen is low anyway.
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      wen0         <= 1'b0;
      wen1         <= 1'b0;
      commit_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_done[i]  <= 1'b0;
      end
    end else begin
      // Bus 1 is written second so it wins on a shared tag.
      if (res0_valid && r_valid[res0_tag]) begin
        r_done[res0_tag] <= 1'b1;
        r_data[res0_tag] <= res0_data;
      end
      if (res1_valid && r_valid[res1_tag]) begin
        r_done[res1_tag] <= 1'b1;
        r_data[res1_tag] <= res1_data;
      end

      // Tail slots are never valid while alloc_ready is high, so they
      // cannot collide with the writeback or retire updates.
      if (w_acc0) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_wen[r_tail]   <= alloc0_wen;
        r_rd[r_tail]    <= alloc0_rd;
      end
      if (w_acc1) begin
        r_valid[w_tail1] <= 1'b1;
        r_done[w_tail1]  <= 1'b0;
        r_wen[w_tail1]   <= alloc1_wen;
        r_rd[w_tail1]    <= alloc1_rd;
      end

      wen0 <= w_fire0 && r_wen[r_head];
      wen1 <= w_fire1 && r_wen[w_head1];
      if (w_fire0) begin
        waddr0          <= r_rd[r_head];
        wdata0          <= r_data[r_head];
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
      end
      if (w_fire1) begin
        waddr1           <= r_rd[w_head1];
        wdata1           <= r_data[w_head1];
        r_valid[w_head1] <= 1'b0;
        r_done[w_head1]  <= 1'b0;
      end

      commit_count <= w_n_ret;
      r_head       <= r_head + TAGW'(w_n_ret);
      r_tail       <= r_tail + TAGW'(w_n_acc);
      r_count      <= r_count + (TAGW+1)'(w_n_acc) - (TAGW+1)'(w_n_ret);
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        alloc0_valid, alloc0_wen, alloc1_valid, alloc1_wen;
  logic [2:0]  alloc0_rd, alloc1_rd;
  logic        alloc_ready;
  logic [5:0]  alloc0_tag, alloc1_tag;
  logic        res0_valid, res1_valid;
  logic [5:0]  res0_tag, res1_tag;
  logic [15:0] res0_data, res1_data;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  commit_count;
  logic [6:0]  occupancy;

  int tests = 0;
  int fails = 0;
  logic [15:0] rf [8];

  always #5 clk = ~clk;

  rob_commit #(.DEPTH(64), .TAGW(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc0_valid(alloc0_valid), .alloc0_wen(alloc0_wen), .alloc0_rd(alloc0_rd),
    .alloc1_valid(alloc1_valid), .alloc1_wen(alloc1_wen), .alloc1_rd(alloc1_rd),
    .alloc_ready(alloc_ready), .alloc0_tag(alloc0_tag), .alloc1_tag(alloc1_tag),
    .res0_valid(res0_valid), .res0_tag(res0_tag), .res0_data(res0_data),
    .res1_valid(res1_valid), .res1_tag(res1_tag), .res1_data(res1_data),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .commit_count(commit_count), .occupancy(occupancy)
  );

  typedef struct {
    logic a0v; logic a0w; logic [2:0] a0rd;
    logic a1v; logic a1w; logic [2:0] a1rd;
    logic r0v; logic [5:0] r0t; logic [15:0] r0d;
    logic r1v; logic [5:0] r1t; logic [15:0] r1d;
    logic e_wen0; logic [2:0] e_wa0; logic [15:0] e_wd0;
    logic e_wen1; logic [2:0] e_wa1; logic [15:0] e_wd1;
    logic [1:0] e_cc; logic [6:0] e_occ; logic e_rdy; logic [5:0] e_tag0;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then sample away from it; a simple register-file model
  // applies port 0 then port 1 like the real consumer.
  task automatic step();
    @(posedge clk);
    #1;
    if (wen0) rf[waddr0] = wdata0;
    if (wen1) rf[waddr1] = wdata1;
  endtask

  task automatic idle_inputs();
    flush = 0;
    alloc0_valid = 0; alloc0_wen = 0; alloc0_rd = 0;
    alloc1_valid = 0; alloc1_wen = 0; alloc1_rd = 0;
    res0_valid = 0; res0_tag = 0; res0_data = 0;
    res1_valid = 0; res1_tag = 0; res1_data = 0;
  endtask

  task automatic alloc2(input logic [2:0] rd0, input logic [2:0] rd1);
    alloc0_valid = 1; alloc0_wen = 1; alloc0_rd = rd0;
    alloc1_valid = 1; alloc1_wen = 1; alloc1_rd = rd1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    //            a0v a0w rd  a1v a1w rd  r0v t  d        r1v t  d        wen0 wa wd       wen1 wa wd       cc occ rdy tag0
    vecs[0]  = '{1, 1, 3, 1, 1, 5, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 2, 1, 2};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 1, 1, 16'h00AA, 0, 0, 0,      0, 0, 0,       0, 0, 0,       0, 2, 1, 2};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 16'h1234, 0, 0, 0,      0, 0, 0,       0, 0, 0,       0, 2, 1, 2};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 3, 16'h1234, 1, 5, 16'h00AA, 2, 0, 1, 2};
    vecs[4]  = '{1, 1, 1, 1, 1, 6, 0, 0, 0,       0, 0, 0,       0, 3, 16'h1234, 0, 5, 16'h00AA, 0, 2, 1, 4};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 3, 16'hBEEF, 0, 3, 16'h1234, 0, 5, 16'h00AA, 0, 2, 1, 4};
    for (int i = 6; i < 10; i++)
      vecs[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,       0, 3, 16'h1234, 0, 5, 16'h00AA, 0, 2, 1, 4};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 16'h0C0C, 0, 0, 0,      0, 3, 16'h1234, 0, 5, 16'h00AA, 0, 2, 1, 4};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 1, 16'h0C0C, 1, 6, 16'hBEEF, 2, 0, 1, 4};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 1, 16'h0C0C, 0, 6, 16'hBEEF, 0, 0, 1, 4};
    vecs[13] = '{1, 1, 2, 1, 1, 2, 0, 0, 0,       0, 0, 0,       0, 1, 16'h0C0C, 0, 6, 16'hBEEF, 0, 2, 1, 6};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 1, 4, 16'h0001, 1, 5, 16'h0002, 0, 1, 16'h0C0C, 0, 6, 16'hBEEF, 0, 2, 1, 6};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 2, 16'h0001, 1, 2, 16'h0002, 2, 0, 1, 6};
    vecs[16] = '{1, 0, 7, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 2, 16'h0001, 0, 2, 16'h0002, 0, 1, 1, 7};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 1, 6, 16'h7777, 0, 0, 0,      0, 2, 16'h0001, 0, 2, 16'h0002, 0, 1, 1, 7};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 7, 16'h7777, 0, 2, 16'h0002, 1, 0, 1, 7};
    vecs[19] = '{0, 0, 0, 1, 1, 4, 0, 0, 0,       0, 0, 0,       0, 7, 16'h7777, 0, 2, 16'h0002, 0, 0, 1, 7};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 1, 7, 16'h5555, 0, 0, 0,      0, 7, 16'h7777, 0, 2, 16'h0002, 0, 0, 1, 7};
    vecs[21] = '{1, 1, 0, 1, 1, 1, 0, 0, 0,       0, 0, 0,       0, 7, 16'h7777, 0, 2, 16'h0002, 0, 2, 1, 9};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 7, 16'h7777, 0, 2, 16'h0002, 0, 2, 1, 9};
    vecs[23] = '{0, 0, 0, 0, 0, 0, 1, 7, 16'h0101, 1, 7, 16'h0202, 0, 7, 16'h7777, 0, 2, 16'h0002, 0, 2, 1, 9};
    vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 0, 16'h0202, 0, 2, 16'h0002, 1, 1, 1, 9};

    do_reset();
    chk("rst_wen0", wen0, 0);
    chk("rst_wen1", wen1, 0);
    chk("rst_waddr0", waddr0, 0);
    chk("rst_wdata1", wdata1, 0);
    chk("rst_cc", commit_count, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag0", alloc0_tag, 0);
    chk("rst_tag1", alloc1_tag, 1);

    for (int v = 0; v < 25; v++) begin
      alloc0_valid = vecs[v].a0v; alloc0_wen = vecs[v].a0w; alloc0_rd = vecs[v].a0rd;
      alloc1_valid = vecs[v].a1v; alloc1_wen = vecs[v].a1w; alloc1_rd = vecs[v].a1rd;
      res0_valid = vecs[v].r0v; res0_tag = vecs[v].r0t; res0_data = vecs[v].r0d;
      res1_valid = vecs[v].r1v; res1_tag = vecs[v].r1t; res1_data = vecs[v].r1d;
      step();
      chk($sformatf("v%0d_wen0", v), wen0, vecs[v].e_wen0);
      chk($sformatf("v%0d_waddr0", v), waddr0, vecs[v].e_wa0);
      chk($sformatf("v%0d_wdata0", v), wdata0, vecs[v].e_wd0);
      chk($sformatf("v%0d_wen1", v), wen1, vecs[v].e_wen1);
      chk($sformatf("v%0d_waddr1", v), waddr1, vecs[v].e_wa1);
      chk($sformatf("v%0d_wdata1", v), wdata1, vecs[v].e_wd1);
      chk($sformatf("v%0d_cc", v), commit_count, vecs[v].e_cc);
      chk($sformatf("v%0d_occ", v), occupancy, vecs[v].e_occ);
      chk($sformatf("v%0d_ready", v), alloc_ready, vecs[v].e_rdy);
      chk($sformatf("v%0d_tag0", v), alloc0_tag, vecs[v].e_tag0);
    end
    idle_inputs();
    chk("rf_same_rd_younger_wins", rf[2], 16'h0002);
    chk("rf_bus1_wins", rf[0], 16'h0202);

    // Fill to 64 with no results.
    do_reset();
    chk("fill_start_occ", occupancy, 0);
    for (int i = 0; i < 32; i++) begin
      alloc2(3'd1, 3'd2);
      step();
      if (i == 30) begin
        chk("fill62_occ", occupancy, 62);
        chk("fill62_ready", alloc_ready, 1);
      end
    end
    chk("full_occ", occupancy, 64);
    chk("full_ready", alloc_ready, 0);
    chk("full_tag0", alloc0_tag, 0);
    step();
    chk("full_alloc_ignored_occ", occupancy, 64);
    chk("full_alloc_ignored_tag0", alloc0_tag, 0);
    idle_inputs();
    res0_valid = 1; res0_tag = 0; res0_data = 16'h0011;
    res1_valid = 1; res1_tag = 1; res1_data = 16'h0022;
    step();
    chk("full_wb_occ", occupancy, 64);
    chk("full_wb_wen0", wen0, 0);
    idle_inputs();
    step();
    chk("full_commit_cc", commit_count, 2);
    chk("full_commit_wdata0", wdata0, 16'h0011);
    chk("full_commit_wdata1", wdata1, 16'h0022);
    chk("full_commit_occ", occupancy, 62);
    chk("full_commit_ready", alloc_ready, 1);
    chk("wrap_tag0", alloc0_tag, 0);
    chk("wrap_tag1", alloc1_tag, 1);
    res0_valid = 1; res0_tag = 2; res0_data = 16'h0033;
    res1_valid = 1; res1_tag = 3; res1_data = 16'h0044;
    step();
    chk("pre_same_cycle_cc", commit_count, 0);
    idle_inputs();
    alloc2(3'd4, 3'd5);
    step();
    idle_inputs();
    chk("same_cycle_occ", occupancy, 62);
    chk("same_cycle_cc", commit_count, 2);
    chk("same_cycle_tag0", alloc0_tag, 2);
    chk("same_cycle_waddr0", waddr0, 1);

    // Flush from a busy state: address/data lines must hold.
    flush = 1;
    step();
    flush = 0;
    chk("flush1_occ", occupancy, 0);
    chk("flush1_waddr0_hold", waddr0, 1);
    chk("flush1_wdata0_hold", wdata0, 16'h0033);
    chk("flush1_wdata1_hold", wdata1, 16'h0044);

    // Ten live entries, then flush with a writeback and alloc in the same cycle.
    for (int i = 0; i < 5; i++) begin
      alloc2(3'd6, 3'd7);
      step();
    end
    idle_inputs();
    chk("live10_occ", occupancy, 10);
    flush = 1;
    alloc2(3'd6, 3'd7);
    res0_valid = 1; res0_tag = 0; res0_data = 16'hAAAA;
    step();
    idle_inputs();
    chk("flush2_occ", occupancy, 0);
    chk("flush2_tag0", alloc0_tag, 0);
    chk("flush2_tag1", alloc1_tag, 1);
    chk("flush2_wen0", wen0, 0);
    chk("flush2_ready", alloc_ready, 1);
    alloc2(3'd3, 3'd4);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_flush%0d_wen0", i), wen0, 0);
      chk($sformatf("post_flush%0d_wen1", i), wen1, 0);
    end
    chk("post_flush_occ", occupancy, 2);

    // Reset on the edge where both entries would commit.
    res0_valid = 1; res0_tag = 0; res0_data = 16'h1111;
    res1_valid = 1; res1_tag = 1; res1_data = 16'h2222;
    step();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    chk("rst_mid_wen0", wen0, 0);
    chk("rst_mid_wen1", wen1, 0);
    chk("rst_mid_cc", commit_count, 0);
    chk("rst_mid_occ", occupancy, 0);
    chk("rst_mid_waddr0", waddr0, 0);
    step();
    chk("rst_mid_after_wen0", wen0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer for the out-of-order core. Allocates up to two entries per cycle in program order and captures results from up to two writeback buses.
- Retires completed entries in order, up to two per cycle.
- Commit outputs drive the register file's two write ports (wen0/waddr0/wdata0, wen1/waddr1/wdata1).
- The 6-bit entry index it hands out is the ROB tag that the register file stores as rob_loc alongside each busy bit.

Parameters:
- DEPTH, 64, number of entries; power of two; sets the tag width.
- TAGW, 6, tag width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous squash of all entries
- alloc0_valid  in  1  allocate the older instruction
- alloc0_wen  in  1  older instruction writes a register
- alloc0_rd  in  3  older destination register
- alloc1_valid  in  1  allocate the younger instruction
- alloc1_wen  in  1  younger instruction writes a register
- alloc1_rd  in  3  younger destination register
- alloc_ready  out  1  at least 2 entries free
- alloc0_tag  out  TAGW  tag given to alloc0 (= tail)
- alloc1_tag  out  TAGW  tag given to alloc1 (= tail+1 mod DEPTH)
- res0_valid  in  1  writeback bus 0 valid
- res0_tag  in  TAGW  writeback bus 0 tag
- res0_data  in  16  writeback bus 0 data
- res1_valid  in  1  writeback bus 1 valid
- res1_tag  in  TAGW  writeback bus 1 tag
- res1_data  in  16  writeback bus 1 data
- wen0  out  1  commit slot 0 register write enable
- waddr0  out  3  commit slot 0 register address
- wdata0  out  16  commit slot 0 register data
- wen1  out  1  commit slot 1 register write enable
- waddr1  out  3  commit slot 1 register address
- wdata1  out  16  commit slot 1 register data
- commit_count  out  2  entries retired last cycle (0..2)
- occupancy  out  TAGW+1  valid entry count

Behaviour:
- State:
  - head and tail pointers, TAGW bits, wrap modulo DEPTH.
  - count, TAGW+1 bits.
  - Per entry: valid, done, wen, rd[2:0], data[15:0].
- Reset: head=tail=count=0; all valid/done cleared; wen0=wen1=0, waddr*=0, wdata*=0, commit_count=0. alloc_ready=1 and alloc tags 0/1 in the cycle after reset.
- alloc_ready, alloc0_tag and alloc1_tag are combinational from registered state. alloc_ready = (count <= DEPTH-2).
- Allocation:
  - Accepted only when alloc_ready=1.
  - alloc1 is honoured only together with alloc0. alloc1_valid without alloc0_valid is ignored.
  - Each accepted entry is written with valid=1, done=0, wen, rd.
  - tail advances by the number accepted. alloc_* while alloc_ready=0 is ignored with no state change.
- Writeback:
  - res*_valid with a tag whose entry is valid sets done=1 and data.
  - A tag whose entry is invalid is ignored.
  - If both buses carry the same tag, bus 1 wins.
- Commit, evaluated on state registered before the edge:
  - Slot 0 fires if entry[head] is valid and done.
  - Slot 1 fires if slot 0 fires and entry[head+1] is valid and done.
  - A result written this cycle is retirable no earlier than the next edge. Minimum writeback-to-wen latency is 2 cycles: result captured at edge N, commit outputs registered at edge N+1.
- Commit outputs are registered. Per slot: wen = fired && entry.wen, waddr = rd, wdata = data.
  - Non-firing slots drive wen=0; waddr/wdata hold their previous values.
  - Retired entries are cleared to valid=0. head advances by commit_count.
  - Entries with wen=0 retire normally and consume a slot.
- Same rd in both slots: both wen asserted. The register file applies port 1 last, so the younger value wins. No merging is done here.
- Occupancy: count_next = count + accepted - retired, applied in the same cycle. Full (64) and empty (0) must hold exactly; no wrap on count.
- Flush (priority below reset, above all else):
  - Next state equals reset state except that waddr/wdata hold.
  - Allocations, writebacks and commits in the flush cycle are dropped.

Test Plan:
- Reset, then alloc0 (wen=1, rd=3) and alloc1 (wen=1, rd=5). Expected: tags 0 and 1, occupancy 2. res0 tag1=0x00AA at edge N, then res0 tag0=0x1234 at edge N+1. Expected: wen0=1, waddr0=3, wdata0=0x1234 and wen1=1, waddr1=5, wdata1=0x00AA after edge N+2, commit_count=2.
- Out-of-order completion: tag1 done, tag0 not done. Expected: no commit for 5 cycles while wen0=wen1=0. Then tag0 done; expected both commit one cycle later.
- Fill with 32 dual allocations, no results. Expected: occupancy=64, alloc_ready=0. A further alloc is ignored with tail unchanged. Complete tag0 and tag1. Expected: after commit, occupancy=62 and alloc_ready=1. Next allocation gets tags 0 and 1 (wrap-around).
- Same-cycle alloc of 2 and commit of 2 at occupancy 62. Expected: occupancy stays 62.
- Two entries both rd=2, data 0x0001 then 0x0002, committed together. Expected: wen0/wen1 both 1, waddr0=waddr1=2. The register file then reads 0x0002. Also retire an entry with wen=0: commit_count=1, wen0=0.
- Flush with 10 entries live and a writeback in the same cycle. Expected: occupancy=0, tags 0/1, no wen for following cycles. Reset asserted mid-commit: wen0=wen1=0 on the next edge.
